completion_data_channel: RTL and testbench
==========================================

Name: completion_data_channel

Overview:
- Stage directly downstream of the completion command channel.
- Accepts one command header at a time, re-issues it on the downstream command port, then moves the matching data phase:
  - Forward command: passes exactly Length data beats from source to destination.
  - Completion report (SourceID == ThisID and TargetID == 0): emits one locally generated report word.
- Raises a one-cycle done pulse when each transfer finishes.

Parameters:
- AddressWidth, 32, command address width
- DataWidth, 32, data beat width
- InnerIFLengthWidth, 16, command length field width (beats)
- ThisID, 1, local ID; identifies completion-report headers

Ports:
- iClock  in  1  clock; all logic on rising edge
- iReset  in  1  asynchronous, active-high reset
- iCmdOpcode  in  6  upstream command opcode
- iCmdTargetID  in  5  upstream target ID
- iCmdSourceID  in  5  upstream source ID
- iCmdAddress  in  AddressWidth  upstream address
- iCmdLength  in  InnerIFLengthWidth  upstream beat count
- iCmdValid  in  1  upstream command valid
- oCmdReady  out  1  command accepted when iCmdValid & oCmdReady
- iReportData  in  DataWidth  completion report word, sampled at command accept
- oDstOpcode  out  6  registered header
- oDstTargetID  out  5  registered header
- oDstSourceID  out  5  registered header
- oDstAddress  out  AddressWidth  registered header
- oDstLength  out  InnerIFLengthWidth  registered header
- oDstCmdValid  out  1  downstream command valid
- iDstCmdReady  in  1  downstream command ready
- iSrcData  in  DataWidth  source data beat
- iSrcDataValid  in  1  source beat valid
- oSrcDataReady  out  1  source beat ready
- oDstData  out  DataWidth  destination data beat
- oDstDataValid  out  1  destination beat valid
- oDstDataLast  out  1  final beat of transfer
- iDstDataReady  in  1  destination beat ready
- oXferDone  out  1  one-cycle pulse, transfer complete

Behaviour:
- Reset (async, iReset=1): state Idle; all header registers, report register and beat counter 0; oDstCmdValid, oDstDataValid, oDstDataLast, oSrcDataReady and oXferDone 0; oCmdReady 1 after reset releases.
- Reset mid-transfer: the transfer is abandoned immediately. No beats are replayed. No done pulse is issued.
- States: Idle, CmdOut, DataFwd, DataReport, Done.
- Idle:
  - oCmdReady = 1.
  - On iCmdValid: latch all header fields into registers, latch iReportData into the report register, load rRemain = iCmdLength, go to CmdOut.
  - Header appears on oDst* exactly 1 cycle after acceptance.
- CmdOut:
  - oDstCmdValid = 1; header fields held stable until the handshake.
  - On iDstCmdReady:
    - If SourceID == ThisID and TargetID == 0: go to DataReport.
    - Else if Length == 0: go to Done.
    - Else: go to DataFwd.
- DataFwd (combinational pass-through, zero added latency):
  - oDstData = iSrcData.
  - oDstDataValid = iSrcDataValid.
  - oSrcDataReady = iDstDataReady.
  - oDstDataLast = (rRemain == 1).
  - A beat transfers when iSrcDataValid & iDstDataReady. rRemain then decrements by 1. If rRemain was 1, go to Done.
  - Outside DataFwd: oSrcDataReady = 0 and source beats are never consumed.
- DataReport:
  - oDstData = report register; oDstDataValid = 1; oDstDataLast = 1.
  - On iDstDataReady: go to Done.
- Done: oXferDone = 1 for exactly one cycle, then Idle. oCmdReady is 0 in this cycle, so back-to-back commands are spaced by at least one cycle.
- Length arithmetic: unsigned, InnerIFLengthWidth bits. Maximum length (all ones) forwards 2^W−1 beats. The counter never wraps because the exit happens at rRemain == 1.
- Simultaneous events: iCmdValid while busy is ignored (oCmdReady = 0). Upstream holds the command.
- Destination stall: with iDstDataReady = 0, data/valid/last are held and rRemain does not change.

Test Plan:
- Forward, no stalls. Cmd Opcode=6'h02, TargetID=3, SourceID=2, Addr=32'h1000, Length=4; data 0xA0..0xA3 with ready held high. Required: header valid 1 cycle after accept; 4 beats in order; oDstDataLast only on 0xA3; oXferDone 1 cycle after 0xA3; oCmdReady back to 1 one cycle later.
- Completion report. SourceID=1, TargetID=0, Length=1, iReportData=32'hDEAD_BEEF. Required: one beat 0xDEADBEEF with last=1; oSrcDataReady stays 0 throughout; one done pulse.
- Zero length. TargetID=3, Length=0. Required: header issued; no data beats; oXferDone 1 cycle after iDstCmdReady.
- Backpressure. Length=3; iDstDataReady toggled 1,0,0,1,1; iDstCmdReady held 0 for 5 cycles first. Required: header stable for all 5 stall cycles; beats held during stalls; exactly 3 beats total; last on 3rd; oSrcDataReady mirrors iDstDataReady.
- Busy rejection. Second cmd asserted during DataFwd of a Length=2 transfer. Required: oCmdReady=0 until after the Done cycle; second header accepted next and forwarded intact.
- Async reset mid-transfer. iReset pulsed between clock edges after 2 of 5 beats. Required: all outputs 0 immediately, without waiting for a clock edge; no oXferDone; a fresh Length=1 cmd then completes normally.

Source files
------------

// File: rtl/completion_data_channel.sv
// completion_data_channel
// Sits behind the completion command channel. Takes one command header at a
// time, re-issues it downstream, then either forwards Length data beats from
// the source to the destination or emits a single locally generated report
// word. A one-cycle done pulse marks the end of every transfer.
//
// Handshake rule for every port pair here: a transfer happens on the rising
// clock edge where valid and ready are both 1. Valid, once raised, holds
// with its payload stable until that edge. Ready may change freely.
module completion_data_channel #(
   parameter int AddressWidth       = 32,
   parameter int DataWidth          = 32,
   parameter int InnerIFLengthWidth = 16,
   parameter int ThisID             = 1
) (
   input  logic                          iClock,
   input  logic                          iReset,
   // upstream command
   input  logic [5:0]                    iCmdOpcode,
   input  logic [4:0]                    iCmdTargetID,
   input  logic [4:0]                    iCmdSourceID,
   input  logic [AddressWidth-1:0]       iCmdAddress,
   input  logic [InnerIFLengthWidth-1:0] iCmdLength,
   input  logic                          iCmdValid,
   output logic                          oCmdReady,
   input  logic [DataWidth-1:0]          iReportData,
   // downstream command
   output logic [5:0]                    oDstOpcode,
   output logic [4:0]                    oDstTargetID,
   output logic [4:0]                    oDstSourceID,
   output logic [AddressWidth-1:0]       oDstAddress,
   output logic [InnerIFLengthWidth-1:0] oDstLength,
   output logic                          oDstCmdValid,
   input  logic                          iDstCmdReady,
   // data path
   input  logic [DataWidth-1:0]          iSrcData,
   input  logic                          iSrcDataValid,
   output logic                          oSrcDataReady,
   output logic [DataWidth-1:0]          oDstData,
   output logic                          oDstDataValid,
   output logic                          oDstDataLast,
   input  logic                          iDstDataReady,
   output logic                          oXferDone,
   // current FSM state, for debug visibility
   output logic [2:0]                    oDebugState
);

   typedef enum logic [2:0] {
      Idle       = 3'd0,
      CmdOut     = 3'd1,
      DataFwd    = 3'd2,
      DataReport = 3'd3,
      Done       = 3'd4
   } state_t;

   localparam logic [4:0]                    cThisID = 5'(ThisID);
   localparam logic [InnerIFLengthWidth-1:0] cOne    = InnerIFLengthWidth'(1);

   state_t                          rState;
   logic [5:0]                      rOpcode;
   logic [4:0]                      rTargetID;
   logic [4:0]                      rSourceID;
   logic [AddressWidth-1:0]         rAddress;
   logic [InnerIFLengthWidth-1:0]   rLength;
   logic [DataWidth-1:0]            rReport;
   logic [InnerIFLengthWidth-1:0]   rRemain;
   logic                            rDstCmdValid;
   logic                            rXferDone;

   logic isReport;
   logic beatFire;

   // A header addressed back to us with target 0 is a completion report.
   assign isReport = (rSourceID == cThisID) && (rTargetID == 5'd0);
   // A forwarded beat moves only while in DataFwd with both sides willing.
   assign beatFire = (rState == DataFwd) && iSrcDataValid && iDstDataReady;

   // Ready only in Idle; forced low while reset is asserted.
   assign oCmdReady = (rState == Idle) && !iReset;

   assign oDstOpcode   = rOpcode;
   assign oDstTargetID = rTargetID;
   assign oDstSourceID = rSourceID;
   assign oDstAddress  = rAddress;
   assign oDstLength   = rLength;
   assign oDstCmdValid = rDstCmdValid;
   assign oXferDone    = rXferDone;
   assign oDebugState  = rState;

   // Transfer sequencing: header capture, command issue, data phase, done pulse.
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         rState       <= Idle;
         rOpcode      <= '0;
         rTargetID    <= '0;
         rSourceID    <= '0;
         rAddress     <= '0;
         rLength      <= '0;
         rReport      <= '0;
         rRemain      <= '0;
         rDstCmdValid <= 1'b0;
         rXferDone    <= 1'b0;
      end else begin
         rXferDone <= 1'b0;
         case (rState)
            Idle: begin
               if (iCmdValid) begin
                  rOpcode      <= iCmdOpcode;
                  rTargetID    <= iCmdTargetID;
                  rSourceID    <= iCmdSourceID;
                  rAddress     <= iCmdAddress;
                  rLength      <= iCmdLength;
                  rReport      <= iReportData;
                  rRemain      <= iCmdLength;
                  rDstCmdValid <= 1'b1;
                  rState       <= CmdOut;
               end
            end
            CmdOut: begin
               if (iDstCmdReady) begin
                  rDstCmdValid <= 1'b0;
                  if (isReport) begin
                     rState <= DataReport;
                  end else if (rLength == '0) begin
                     rState    <= Done;
                     rXferDone <= 1'b1;
                  end else begin
                     rState <= DataFwd;
                  end
               end
            end
            DataFwd: begin
               // Exit on the beat that consumes the last remaining count, so
               // the counter never has to pass through zero.
               if (beatFire) begin
                  rRemain <= rRemain - cOne;
                  if (rRemain == cOne) begin
                     rState    <= Done;
                     rXferDone <= 1'b1;
                  end
               end
            end
            DataReport: begin
               if (iDstDataReady) begin
                  rState    <= Done;
                  rXferDone <= 1'b1;
               end
            end
            Done: begin
               rState <= Idle;
            end
            default: begin
               rState <= Idle;
            end
         endcase
      end
   end

   // Data-phase muxing: zero-latency pass-through when forwarding, report
   // word when reporting, everything quiet otherwise.
   always_comb begin
      oDstData      = '0;
      oDstDataValid = 1'b0;
      oDstDataLast  = 1'b0;
      oSrcDataReady = 1'b0;
      case (rState)
         DataFwd: begin
            oDstData      = iSrcData;
            oDstDataValid = iSrcDataValid;
            oDstDataLast  = (rRemain == cOne);
            oSrcDataReady = iDstDataReady;
         end
         DataReport: begin
            oDstData      = rReport;
            oDstDataValid = 1'b1;
            oDstDataLast  = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_completion_data_channel.sv
// Directed bench for completion_data_channel. Inputs change on the falling
// edge; outputs are sampled 1 time unit later, well before the next rising edge.
module tb_completion_data_channel;

   logic        iClock = 1'b0;
   logic        iReset;
   logic [5:0]  iCmdOpcode;
   logic [4:0]  iCmdTargetID;
   logic [4:0]  iCmdSourceID;
   logic [31:0] iCmdAddress;
   logic [15:0] iCmdLength;
   logic        iCmdValid;
   logic        oCmdReady;
   logic [31:0] iReportData;
   logic [5:0]  oDstOpcode;
   logic [4:0]  oDstTargetID;
   logic [4:0]  oDstSourceID;
   logic [31:0] oDstAddress;
   logic [15:0] oDstLength;
   logic        oDstCmdValid;
   logic        iDstCmdReady;
   logic [31:0] iSrcData;
   logic        iSrcDataValid;
   logic        oSrcDataReady;
   logic [31:0] oDstData;
   logic        oDstDataValid;
   logic        oDstDataLast;
   logic        iDstDataReady;
   logic        oXferDone;
   logic [2:0]  oDebugState;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   completion_data_channel #(
      .AddressWidth(32), .DataWidth(32), .InnerIFLengthWidth(16), .ThisID(1)
   ) dut (
      .iClock(iClock), .iReset(iReset),
      .iCmdOpcode(iCmdOpcode), .iCmdTargetID(iCmdTargetID), .iCmdSourceID(iCmdSourceID),
      .iCmdAddress(iCmdAddress), .iCmdLength(iCmdLength), .iCmdValid(iCmdValid),
      .oCmdReady(oCmdReady), .iReportData(iReportData),
      .oDstOpcode(oDstOpcode), .oDstTargetID(oDstTargetID), .oDstSourceID(oDstSourceID),
      .oDstAddress(oDstAddress), .oDstLength(oDstLength), .oDstCmdValid(oDstCmdValid),
      .iDstCmdReady(iDstCmdReady),
      .iSrcData(iSrcData), .iSrcDataValid(iSrcDataValid), .oSrcDataReady(oSrcDataReady),
      .oDstData(oDstData), .oDstDataValid(oDstDataValid), .oDstDataLast(oDstDataLast),
      .iDstDataReady(iDstDataReady), .oXferDone(oXferDone), .oDebugState(oDebugState)
   );

   // clock / reset
   always #5 iClock = ~iClock;

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      iCmdOpcode    = '0;
      iCmdTargetID  = '0;
      iCmdSourceID  = '0;
      iCmdAddress   = '0;
      iCmdLength    = '0;
      iCmdValid     = 1'b0;
      iReportData   = '0;
      iDstCmdReady  = 1'b0;
      iSrcData      = '0;
      iSrcDataValid = 1'b0;
      iDstDataReady = 1'b0;
   endtask

   task automatic drive_cmd(input logic [5:0] opc, input logic [4:0] tid, input logic [4:0] sid,
                            input logic [31:0] addr, input logic [15:0] len, input logic [31:0] rep);
      iCmdOpcode   = opc;
      iCmdTargetID = tid;
      iCmdSourceID = sid;
      iCmdAddress  = addr;
      iCmdLength   = len;
      iReportData  = rep;
      iCmdValid    = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      iReset = 1'b1;
      drive_idle();
      @(negedge iClock); #1;
      checks++; if (oCmdReady !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b want 0", oCmdReady); end
      checks++; if ({oDstCmdValid, oDstDataValid, oDstDataLast, oSrcDataReady, oXferDone} !== 5'b0) begin
         errors++; $display("FAIL rst_ctrl_outs: got %b want 00000",
                            {oDstCmdValid, oDstDataValid, oDstDataLast, oSrcDataReady, oXferDone}); end
      checks++; if ({oDstOpcode, oDstTargetID, oDstSourceID, oDstAddress, oDstLength} !== 64'd0) begin
         errors++; $display("FAIL rst_header: got %h want 0",
                            {oDstOpcode, oDstTargetID, oDstSourceID, oDstAddress, oDstLength}); end
      checks++; if (oDebugState !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", oDebugState); end
      iReset = 1'b0; #1;
      checks++; if (oCmdReady !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", oCmdReady); end
   endtask

   task automatic test_forward_basic();
      logic [31:0] exp;
      exp_q = {};
      for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + i);
      @(negedge iClock);
      drive_cmd(6'h02, 5'd3, 5'd2, 32'h1000, 16'd4, 32'h0);
      iDstCmdReady = 1'b1; iDstDataReady = 1'b1;
      #1;
      checks++; if (oCmdReady !== 1'b1) begin errors++; $display("FAIL fwd_accept_ready: got %b want 1", oCmdReady); end
      checks++; if (oDstCmdValid !== 1'b0) begin errors++; $display("FAIL fwd_hdr_early: got %b want 0", oDstCmdValid); end
      @(negedge iClock); iCmdValid = 1'b0; #1;
      checks++; if (oDstCmdValid !== 1'b1) begin errors++; $display("FAIL fwd_hdr_valid: got %b want 1", oDstCmdValid); end
      checks++; if ({oDstOpcode, oDstTargetID, oDstSourceID, oDstAddress, oDstLength} !== {6'h02, 5'd3, 5'd2, 32'h1000, 16'd4}) begin
         errors++; $display("FAIL fwd_hdr_fields: got %h want %h",
                            {oDstOpcode, oDstTargetID, oDstSourceID, oDstAddress, oDstLength},
                            {6'h02, 5'd3, 5'd2, 32'h1000, 16'd4}); end
      checks++; if (oCmdReady !== 1'b0) begin errors++; $display("FAIL fwd_busy_ready: got %b want 0", oCmdReady); end
      for (int i = 0; i < 4; i++) begin
         @(negedge iClock); iSrcData = 32'hA0 + i; iSrcDataValid = 1'b1; #1;
         exp = exp_q.pop_front();
         checks++; if ({oDstDataValid, oSrcDataReady} !== 2'b11) begin
            errors++; $display("FAIL fwd_beat%0d_vr: got %b want 11", i, {oDstDataValid, oSrcDataReady}); end
         checks++; if (oDstData !== exp) begin errors++; $display("FAIL fwd_beat%0d_data: got %h want %h", i, oDstData, exp); end
         checks++; if (oDstDataLast !== 1'(i == 3)) begin
            errors++; $display("FAIL fwd_beat%0d_last: got %b want %b", i, oDstDataLast, 1'(i == 3)); end
         checks++; if (oXferDone !== 1'b0) begin errors++; $display("FAIL fwd_beat%0d_done: got %b want 0", i, oXferDone); end
      end
      @(negedge iClock); iSrcDataValid = 1'b0; #1;
      checks++; if (oXferDone !== 1'b1) begin errors++; $display("FAIL fwd_done_pulse: got %b want 1", oXferDone); end
      checks++; if (oCmdReady !== 1'b0) begin errors++; $display("FAIL fwd_done_ready: got %b want 0", oCmdReady); end
      @(negedge iClock); #1;
      checks++; if ({oXferDone, oCmdReady} !== 2'b01) begin
         errors++; $display("FAIL fwd_after_done: got done,ready=%b want 01", {oXferDone, oCmdReady}); end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL fwd_queue_empty: got %0d want 0", exp_q.size()); end
      drive_idle();
   endtask

   task automatic test_report();
      @(negedge iClock);
      drive_cmd(6'h0A, 5'd0, 5'd1, 32'h2000, 16'd1, 32'hDEAD_BEEF);
      iDstCmdReady = 1'b1; iDstDataReady = 1'b1;
      iSrcData = 32'h5555_5555; iSrcDataValid = 1'b1;
      #1;
      checks++; if (oSrcDataReady !== 1'b0) begin errors++; $display("FAIL rpt_srcrdy_idle: got %b want 0", oSrcDataReady); end
      @(negedge iClock); iCmdValid = 1'b0; iReportData = 32'h0; #1;
      checks++; if ({oDstCmdValid, oDstSourceID, oDstTargetID} !== {1'b1, 5'd1, 5'd0}) begin
         errors++; $display("FAIL rpt_hdr: got %h want %h", {oDstCmdValid, oDstSourceID, oDstTargetID}, {1'b1, 5'd1, 5'd0}); end
      checks++; if (oSrcDataReady !== 1'b0) begin errors++; $display("FAIL rpt_srcrdy_cmd: got %b want 0", oSrcDataReady); end
      @(negedge iClock); #1;
      checks++; if ({oDstDataValid, oDstDataLast} !== 2'b11) begin
         errors++; $display("FAIL rpt_valid_last: got %b want 11", {oDstDataValid, oDstDataLast}); end
      checks++; if (oDstData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rpt_data: got %h want deadbeef", oDstData); end
      checks++; if (oSrcDataReady !== 1'b0) begin errors++; $display("FAIL rpt_srcrdy_data: got %b want 0", oSrcDataReady); end
      @(negedge iClock); #1;
      checks++; if ({oXferDone, oSrcDataReady, oDstDataValid} !== 3'b100) begin
         errors++; $display("FAIL rpt_done: got done,srdy,dvalid=%b want 100", {oXferDone, oSrcDataReady, oDstDataValid}); end
      @(negedge iClock); #1;
      checks++; if (oXferDone !== 1'b0) begin errors++; $display("FAIL rpt_single_pulse: got %b want 0", oXferDone); end
      drive_idle();
   endtask

   task automatic test_zero_length();
      @(negedge iClock);
      drive_cmd(6'h01, 5'd3, 5'd2, 32'h3000, 16'd0, 32'h0);
      iSrcDataValid = 1'b1; iSrcData = 32'h7777_7777; iDstDataReady = 1'b1;
      @(negedge iClock); iCmdValid = 1'b0; #1;
      checks++; if ({oDstCmdValid, oDstLength, oDstAddress} !== {1'b1, 16'd0, 32'h3000}) begin
         errors++; $display("FAIL zl_hdr: got %h want %h", {oDstCmdValid, oDstLength, oDstAddress}, {1'b1, 16'd0, 32'h3000}); end
      @(negedge iClock); iDstCmdReady = 1'b1; #1;
      checks++; if ({oDstCmdValid, oDstDataValid, oXferDone} !== 3'b100) begin
         errors++; $display("FAIL zl_hold: got %b want 100", {oDstCmdValid, oDstDataValid, oXferDone}); end
      @(negedge iClock); #1;
      checks++; if ({oXferDone, oDstDataValid, oSrcDataReady} !== 3'b100) begin
         errors++; $display("FAIL zl_done: got %b want 100", {oXferDone, oDstDataValid, oSrcDataReady}); end
      @(negedge iClock); #1;
      checks++; if ({oXferDone, oCmdReady} !== 2'b01) begin
         errors++; $display("FAIL zl_idle: got %b want 01", {oXferDone, oCmdReady}); end
      drive_idle();
   endtask

   task automatic test_backpressure();
      logic [4:0] rdy_pat;
      int         beat_idx;
      rdy_pat  = 5'b11001; // applied LSB first: 1,0,0,1,1
      beat_idx = 0;
      @(negedge iClock);
      drive_cmd(6'h03, 5'd4, 5'd2, 32'h4000, 16'd3, 32'h0);
      @(negedge iClock); iCmdValid = 1'b0; iCmdOpcode = 6'h3F; iCmdAddress = 32'hFFFF_FFFF;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++; if ({oDstCmdValid, oDstOpcode, oDstTargetID, oDstAddress, oDstLength} !== {1'b1, 6'h03, 5'd4, 32'h4000, 16'd3}) begin
            errors++; $display("FAIL bp_hdr_stall%0d: got %h want %h", c,
                               {oDstCmdValid, oDstOpcode, oDstTargetID, oDstAddress, oDstLength},
                               {1'b1, 6'h03, 5'd4, 32'h4000, 16'd3}); end
         @(negedge iClock);
      end
      iDstCmdReady = 1'b1; #1;
      checks++; if (oDstCmdValid !== 1'b1) begin errors++; $display("FAIL bp_hdr_final: got %b want 1", oDstCmdValid); end
      for (int c = 0; c < 5; c++) begin
         @(negedge iClock);
         iDstCmdReady  = 1'b0;
         iDstDataReady = rdy_pat[c];
         iSrcDataValid = 1'b1;
         iSrcData      = 32'hB0 + beat_idx;
         #1;
         checks++; if (oSrcDataReady !== rdy_pat[c]) begin
            errors++; $display("FAIL bp_srcrdy_c%0d: got %b want %b", c, oSrcDataReady, rdy_pat[c]); end
         checks++; if ({oDstDataValid, oDstData} !== {1'b1, 32'hB0 + 32'(beat_idx)}) begin
            errors++; $display("FAIL bp_data_c%0d: got %h want %h", c, {oDstDataValid, oDstData}, {1'b1, 32'hB0 + 32'(beat_idx)}); end
         checks++; if (oDstDataLast !== 1'(beat_idx == 2)) begin
            errors++; $display("FAIL bp_last_c%0d: got %b want %b", c, oDstDataLast, 1'(beat_idx == 2)); end
         if (rdy_pat[c]) beat_idx++;
      end
      @(negedge iClock); iSrcDataValid = 1'b0; #1;
      checks++; if (oXferDone !== 1'b1) begin errors++; $display("FAIL bp_done: got %b want 1", oXferDone); end
      checks++; if (beat_idx !== 3) begin errors++; $display("FAIL bp_beat_count: got %0d want 3", beat_idx); end
      drive_idle();
   endtask

   task automatic test_busy_rejection();
      @(negedge iClock);
      drive_cmd(6'h04, 5'd5, 5'd2, 32'h5000, 16'd2, 32'h0);
      iDstCmdReady = 1'b1; iDstDataReady = 1'b1;
      @(negedge iClock);
      drive_cmd(6'h06, 5'd6, 5'd3, 32'h6000, 16'd1, 32'h0);
      #1;
      checks++; if (oCmdReady !== 1'b0) begin errors++; $display("FAIL busy_ready_cmdout: got %b want 0", oCmdReady); end
      checks++; if ({oDstOpcode, oDstAddress, oDstLength} !== {6'h04, 32'h5000, 16'd2}) begin
         errors++; $display("FAIL busy_hdr_a: got %h want %h", {oDstOpcode, oDstAddress, oDstLength}, {6'h04, 32'h5000, 16'd2}); end
      for (int i = 0; i < 2; i++) begin
         @(negedge iClock); iSrcData = 32'hC0 + i; iSrcDataValid = 1'b1; #1;
         checks++; if ({oCmdReady, oDstDataValid, oDstData} !== {1'b0, 1'b1, 32'hC0 + 32'(i)}) begin
            errors++; $display("FAIL busy_beat%0d: got %h want %h", i, {oCmdReady, oDstDataValid, oDstData}, {1'b0, 1'b1, 32'hC0 + 32'(i)}); end
      end
      @(negedge iClock); iSrcDataValid = 1'b0; #1;
      checks++; if ({oXferDone, oCmdReady} !== 2'b10) begin
         errors++; $display("FAIL busy_done_cycle: got %b want 10", {oXferDone, oCmdReady}); end
      @(negedge iClock); #1;
      checks++; if (oCmdReady !== 1'b1) begin errors++; $display("FAIL busy_ready_again: got %b want 1", oCmdReady); end
      @(negedge iClock); iCmdValid = 1'b0; #1;
      checks++; if ({oDstCmdValid, oDstOpcode, oDstTargetID, oDstSourceID, oDstAddress, oDstLength} !==
                    {1'b1, 6'h06, 5'd6, 5'd3, 32'h6000, 16'd1}) begin
         errors++; $display("FAIL busy_hdr_b: got %h want %h",
                            {oDstCmdValid, oDstOpcode, oDstTargetID, oDstSourceID, oDstAddress, oDstLength},
                            {1'b1, 6'h06, 5'd6, 5'd3, 32'h6000, 16'd1}); end
      @(negedge iClock); iSrcData = 32'hD0; iSrcDataValid = 1'b1; #1;
      checks++; if ({oDstDataValid, oDstDataLast, oDstData} !== {2'b11, 32'hD0}) begin
         errors++; $display("FAIL busy_b_beat: got %h want %h", {oDstDataValid, oDstDataLast, oDstData}, {2'b11, 32'hD0}); end
      @(negedge iClock); iSrcDataValid = 1'b0; #1;
      checks++; if (oXferDone !== 1'b1) begin errors++; $display("FAIL busy_b_done: got %b want 1", oXferDone); end
      drive_idle();
   endtask

   task automatic test_async_reset();
      @(negedge iClock);
      drive_cmd(6'h07, 5'd2, 5'd4, 32'h7000, 16'd5, 32'h0);
      iDstCmdReady = 1'b1; iDstDataReady = 1'b1;
      @(negedge iClock); iCmdValid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge iClock); iSrcData = 32'hE0 + i; iSrcDataValid = 1'b1;
      end
      @(negedge iClock); iSrcData = 32'hE2; #1;
      checks++; if (oDstDataValid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %b want 1", oDstDataValid); end
      iReset = 1'b1; #1;
      checks++; if ({oCmdReady, oDstCmdValid, oDstDataValid, oDstDataLast, oSrcDataReady, oXferDone} !== 6'b0) begin
         errors++; $display("FAIL ar_outs_zero: got %b want 000000",
                            {oCmdReady, oDstCmdValid, oDstDataValid, oDstDataLast, oSrcDataReady, oXferDone}); end
      checks++; if ({oDstOpcode, oDstAddress, oDstLength, oDstData} !== 86'd0) begin
         errors++; $display("FAIL ar_regs_zero: got %h want 0", {oDstOpcode, oDstAddress, oDstLength, oDstData}); end
      #1 iReset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge iClock); #1;
         checks++; if ({oXferDone, oDstDataValid, oCmdReady} !== 3'b001) begin
            errors++; $display("FAIL ar_quiet%0d: got %b want 001", i, {oXferDone, oDstDataValid, oCmdReady}); end
      end
      iSrcDataValid = 1'b0;
      @(negedge iClock);
      drive_cmd(6'h08, 5'd1, 5'd2, 32'h8000, 16'd1, 32'h0);
      @(negedge iClock); iCmdValid = 1'b0; #1;
      checks++; if ({oDstCmdValid, oDstLength} !== {1'b1, 16'd1}) begin
         errors++; $display("FAIL ar_fresh_hdr: got %h want %h", {oDstCmdValid, oDstLength}, {1'b1, 16'd1}); end
      @(negedge iClock); iSrcData = 32'hF0; iSrcDataValid = 1'b1; #1;
      checks++; if ({oDstDataValid, oDstDataLast, oDstData} !== {2'b11, 32'hF0}) begin
         errors++; $display("FAIL ar_fresh_beat: got %h want %h", {oDstDataValid, oDstDataLast, oDstData}, {2'b11, 32'hF0}); end
      @(negedge iClock); iSrcDataValid = 1'b0; #1;
      checks++; if (oXferDone !== 1'b1) begin errors++; $display("FAIL ar_fresh_done: got %b want 1", oXferDone); end
      drive_idle();
   endtask

   initial begin
      test_reset();
      test_forward_basic();
      test_report();
      test_zero_length();
      test_backpressure();
      test_busy_rejection();
      test_async_reset();
      @(negedge iClock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
